// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared types and helpers for the EX-stage forwarding and load-use hazard unit.
// Holds the per-stage shadow record format and the operand-select encoding.
package forwarding_hazard_unit_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs1_used;
    logic                  rs2_used;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } stage_rec_t;

  // A stage produces a value for src only if it really writes a non-x0 register.
  function automatic logic produces(input stage_rec_t p, input logic [REG_ADDR_W-1:0] src);
    return p.valid & p.reg_write & (p.rd != '0) & (p.rd == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic ex_valid,
                                         input logic src_used,
                                         input logic [REG_ADDR_W-1:0] src,
                                         input stage_rec_t mem,
                                         input stage_rec_t wb);
    logic [1:0] sel;
    sel = FWD_REG;
    if (ex_valid & src_used) begin
      if (produces(mem, src))     sel = FWD_MEM;
      else if (produces(wb, src)) sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/forwarding_hazard_unit_stage_reg.sv
// Resettable pipeline shadow-record register; bubble loads an invalid record.
module hazard_stage_reg
  import forwarding_hazard_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       bubble,
  input  stage_rec_t d,
  output stage_rec_t q
);

  stage_rec_t rec_d;
  stage_rec_t rec_q;

  always_comb begin
    rec_d = d;
    if (bubble) rec_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) rec_q <= '0;
    else       rec_q <= rec_d;
  end

  assign q = rec_q;

endmodule

// File: rtl/forwarding_hazard_unit.sv
// EX-stage operand forwarding selects plus load-use stall/bubble generation,
// driven from private shadow copies of the ID/EX, EX/MEM and MEM/WB fields.
module forwarding_hazard_unit #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall,
  output logic                  bubble
);
  import forwarding_hazard_unit_pkg::*;

  stage_rec_t id_rec;
  stage_rec_t ex_q;
  stage_rec_t mem_q;
  stage_rec_t wb_q;
  logic       lu;

  always_comb begin
    id_rec           = '0;
    id_rec.valid     = id_valid;
    id_rec.rs1       = id_rs1;
    id_rec.rs2       = id_rs2;
    id_rec.rs1_used  = id_rs1_used;
    id_rec.rs2_used  = id_rs2_used;
    id_rec.rd        = id_rd;
    id_rec.reg_write = id_reg_write;
    id_rec.mem_read  = id_mem_read;
  end

  hazard_stage_reg u_ex (
    .clk    (clk),
    .reset  (reset),
    .bubble (bubble),
    .d      (id_rec),
    .q      (ex_q)
  );

  hazard_stage_reg u_mem (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  hazard_stage_reg u_wb (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  always_comb begin
    lu = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
         ((id_rs1_used & (ex_q.rd == id_rs1)) | (id_rs2_used & (ex_q.rd == id_rs2)));
    // A flushed instruction is discarded, so it must never hold the front end.
    stall     = lu & ~flush;
    bubble    = lu | flush;
    forward_a = fwd_sel(ex_q.valid, ex_q.rs1_used, ex_q.rs1, mem_q, wb_q);
    forward_b = fwd_sel(ex_q.valid, ex_q.rs2_used, ex_q.rs2, mem_q, wb_q);
  end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed scoreboard bench for forwarding_hazard_unit: the driver queues the
// hand-derived outputs for each checked cycle, a monitor pops and compares.
module tb_forwarding_hazard_unit;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       flush;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic       stall;
  logic       bubble;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  typedef struct {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       bu;
    string      nm;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;
  logic drv_done = 1'b0;

  forwarding_hazard_unit #(.REG_ADDR_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .stall        (stall),
    .bubble       (bubble)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic instr_t nop();
    return '0;
  endfunction

  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t i;
    i = '0; i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    i.u1 = 1'b1; i.u2 = 1'b1; i.rw = 1'b1;
    return i;
  endfunction

  function automatic instr_t imm(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2_junk);
    instr_t i;
    i = '0; i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2_junk;
    i.u1 = 1'b1; i.u2 = 1'b0; i.rw = 1'b1;
    return i;
  endfunction

  function automatic instr_t lw(input logic [4:0] rd, input logic [4:0] rs1);
    instr_t i;
    i = imm(rd, rs1, 5'd0);
    i.mr = 1'b1;
    return i;
  endfunction

  // One clock of stimulus; chk=1 queues the expected outputs for this cycle.
  task automatic step(input logic rst, input instr_t i, input logic fl, input logic chk,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic st, input logic bu, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    id_valid     = i.v;
    id_rs1       = i.rs1;
    id_rs2       = i.rs2;
    id_rs1_used  = i.u1;
    id_rs2_used  = i.u2;
    id_rd        = i.rd;
    id_reg_write = i.rw;
    id_mem_read  = i.mr;
    flush        = fl;
    if (chk) begin
      e.fa = fa; e.fb = fb; e.st = st; e.bu = bu; e.nm = nm;
      scb.push_back(e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (scb.size() > 0) begin
        e = scb.pop_front();
        checks++;
        if (forward_a !== e.fa || forward_b !== e.fb || stall !== e.st || bubble !== e.bu) begin
          errors++;
          $display("FAIL %s: got fa=%b fb=%b stall=%b bubble=%b, expected fa=%b fb=%b stall=%b bubble=%b",
                   e.nm, forward_a, forward_b, stall, bubble, e.fa, e.fb, e.st, e.bu);
        end
      end
    end
  end

  initial begin : driver
    instr_t r;
    reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0;
    id_rs2_used = 1'b0; id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;

    for (int unsigned k = 0; k < 2; k++) begin
      r = instr_t'($urandom);
      step(1'b1, r, 1'($urandom), 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "");
    end
    step(1'b0, nop(), 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "reset_state");

    // add x5 ; sub x6,x5,x7
    step(1'b0, alu(5'd5, 5'd1, 5'd2),  1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "exmem_a0");
    step(1'b0, alu(5'd6, 5'd5, 5'd7),  1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "exmem_a1");
    step(1'b0, nop(),                  1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, "exmem_fwd");
    step(1'b0, nop(),                  1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "ex_invalid");

    // two writers of x5 then a reader: newest producer wins
    step(1'b0, alu(5'd5, 5'd1, 5'd2),   1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "prio_w1");
    step(1'b0, alu(5'd5, 5'd3, 5'd4),   1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "prio_w2");
    step(1'b0, alu(5'd10, 5'd5, 5'd11), 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "prio_rd");
    step(1'b0, nop(),                   1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, "prio_fwd");

    // single writer of x12, reader two instructions later on rs2
    step(1'b0, alu(5'd12, 5'd1, 5'd2),  1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "wb_w");
    step(1'b0, nop(),                   1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "wb_gap");
    step(1'b0, alu(5'd13, 5'd14, 5'd12),1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "wb_rd");
    step(1'b0, nop(),                   1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, "wb_fwd");

    // lw x8 ; add x9,x8,x8
    step(1'b0, lw(5'd8, 5'd1),          1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "lu_load");
    step(1'b0, alu(5'd9, 5'd8, 5'd8),   1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, "lu_detect");
    step(1'b0, alu(5'd9, 5'd8, 5'd8),   1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "lu_held");
    step(1'b0, nop(),                   1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, "lu_fwd_wb");

    // lw x0 ; add x1,x0,x0
    step(1'b0, lw(5'd0, 5'd1),          1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "x0_load");
    step(1'b0, alu(5'd1, 5'd0, 5'd0),   1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "x0_nostall");
    step(1'b0, nop(),                   1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "x0_nofwd");

    // lw x3 ; instruction with rs2=3 unused (lw reads x1 written by add x1 in wb)
    step(1'b0, lw(5'd3, 5'd1),          1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "unused_load");
    step(1'b0, imm(5'd15, 5'd4, 5'd3),  1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, "unused_nostall");

    // flush coinciding with a load-use hazard, then a flush alone
    step(1'b0, lw(5'd20, 5'd0),         1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "flush_load");
    step(1'b0, alu(5'd21, 5'd20, 5'd2), 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, "flush_lu");
    step(1'b0, nop(),                   1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "flush_next");
    step(1'b0, alu(5'd22, 5'd1, 5'd1),  1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, "flush_only");
    step(1'b0, nop(),                   1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "flush_killed");

    // reset in the middle of a load-use stall
    step(1'b0, lw(5'd8, 5'd1),          1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "rst_load");
    step(1'b0, alu(5'd9, 5'd8, 5'd0),   1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, "rst_detect");
    step(1'b0, alu(5'd9, 5'd8, 5'd0),   1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "");
    step(1'b1, alu(5'd9, 5'd8, 5'd0),   1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "");
    step(1'b0, nop(),                   1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "rst_cleared");
    step(1'b0, alu(5'd9, 5'd8, 5'd0),   1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "rst_no_stall");

    step(1'b0, nop(), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "");
    step(1'b0, nop(), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "");
    drv_done = 1'b1;
  end

  initial begin : finisher
    wait (drv_done);
    if (scb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", scb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected driver completion");
    $fatal(1);
  end

endmodule
